ula_sequencial: RTL and testbench

ULA_SEQUENCIAL -- requirements
Module: ula_sequencial

---
 rtl/ula_sequencial.sv | 143 ++++++++++++++
 tb/tb_ula_sequencial.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle add/sub/AND, WIDTH-cycle shift-add multiply.
// Results are held in output registers between valido pulses.
module ula_sequencial #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] M1,
    input  logic [WIDTH-1:0] M2,
    input  logic [1:0]       H,
    input  logic             inicio,
    output logic             pronto,
    output logic             valido,
    output logic [WIDTH-1:0] resultado,
    output logic             estouro
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        FIM
    } estado_t;

    estado_t estado_q, estado_d;

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] parcial;
    logic [2*WIDTH-1:0] produto;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   res_q;
    logic               est_q;

    logic [WIDTH:0]     soma;
    logic [WIDTH:0]     dif;
    logic [WIDTH-1:0]   imm_r;
    logic               imm_e;
    logic               aceita;
    logic               ultimo;

    assign aceita = inicio && (estado_q == OCIOSO);
    assign ultimo = (estado_q == CALCULA) && (cnt_q == ULTIMO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        pronto   = 1'b0;
        valido   = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                pronto = 1'b1;
                if (inicio) begin
                    estado_d = (H == 2'b01) ? CALCULA : FIM;
                end
            end
            CALCULA: begin
                if (cnt_q == ULTIMO) begin
                    estado_d = FIM;
                end
            end
            FIM: begin
                valido   = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Borrow out of the extended subtraction is exactly M1 < M2.
    assign soma = {1'b0, M1} + {1'b0, M2};
    assign dif  = {1'b0, M1} - {1'b0, M2};

    always_comb begin
        imm_r = '0;
        imm_e = 1'b0;
        unique case (H)
            2'b00: begin
                imm_r = soma[WIDTH-1:0];
                imm_e = soma[WIDTH];
            end
            2'b10: begin
                imm_r = dif[WIDTH-1:0];
                imm_e = dif[WIDTH];
            end
            2'b11: begin
                imm_r = M1 & M2;
                imm_e = 1'b0;
            end
            default: begin
                imm_r = '0;
                imm_e = 1'b0;
            end
        endcase
    end

    assign parcial = mplier_q[0] ? mcand_q : '0;
    assign produto = acc_q + parcial;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            est_q    <= 1'b0;
        end else if (aceita) begin
            mcand_q  <= {{WIDTH{1'b0}}, M1};
            mplier_q <= M2;
            acc_q    <= '0;
            cnt_q    <= '0;
            if (H != 2'b01) begin
                res_q <= imm_r;
                est_q <= imm_e;
            end
        end else if (estado_q == CALCULA) begin
            acc_q    <= produto;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            // Outputs only change once the full product is known.
            if (ultimo) begin
                res_q <= produto[WIDTH-1:0];
                est_q <= |produto[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign resultado = res_q;
    assign estouro   = est_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Scoreboard bench for ula_sequencial (WIDTH=16): directed vectors,
// expected result/flag/cycle queued at issue and checked by a monitor.
module tb_ula_sequencial;

    logic        clock;
    logic        reset;
    logic [15:0] M1;
    logic [15:0] M2;
    logic [1:0]  H;
    logic        inicio;
    logic        pronto;
    logic        valido;
    logic [15:0] resultado;
    logic        estouro;

    typedef struct {
        logic [15:0] r;
        logic        e;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    ula_sequencial #(.WIDTH(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .M1       (M1),
        .M2       (M2),
        .H        (H),
        .inicio   (inicio),
        .pronto   (pronto),
        .valido   (valido),
        .resultado(resultado),
        .estouro  (estouro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (valido) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valido: resultado %h at cycle %0d",
                         resultado, cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("resultado", 32'(resultado), 32'(x.r));
                chk("estouro", 32'(estouro), 32'(x.e));
                chk("latency", 32'(cyc), 32'(x.c));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er,
                         input logic ee, input bit track);
        int n;
        exp_t x;
        n = 0;
        while (!pronto && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!pronto) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: pronto %0b required 1", pronto);
        end
        H      = op;
        M1     = a;
        M2     = b;
        inicio = 1'b1;
        x.r = er;
        x.e = ee;
        x.c = cyc + 1 + ((op == 2'b01) ? 16 : 0);
        if (track) sb.push_back(x);
        @(negedge clock);
        inicio = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int c0;
        exp_t x;
        reset  = 1'b1;
        inicio = 1'b0;
        M1     = '0;
        M2     = '0;
        H      = '0;
        #3;
        chk("rst_resultado", 32'(resultado), 32'h0);
        chk("rst_estouro", 32'(estouro), 32'h0);
        chk("rst_valido", 32'(valido), 32'h0);
        chk("rst_pronto", 32'(pronto), 32'h1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        issue(2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
        issue(2'b00, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b1);
        issue(2'b10, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b1);
        issue(2'b10, 16'h0007, 16'h0005, 16'h0002, 1'b0, 1'b1);
        issue(2'b11, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b1);
        drain();

        issue(2'b01, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b1);
        for (int i = 0; i <= 16; i++) begin
            chk("mul_pronto_low", 32'(pronto), 32'h0);
            if (i == 8) chk("mul_hold_res", 32'(resultado), 32'hF000);
            if (i < 16) @(negedge clock);
        end
        @(negedge clock);
        chk("mul_pronto_back", 32'(pronto), 32'h1);

        issue(2'b01, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
        issue(2'b01, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        issue(2'b01, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
        issue(2'b01, 16'h1234, 16'h0010, 16'h2340, 1'b1, 1'b1);
        drain();

        issue(2'b01, 16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b1);
        repeat (3) @(negedge clock);
        H      = 2'b00;
        M1     = 16'h0001;
        M2     = 16'h0001;
        inicio = 1'b1;
        @(negedge clock);
        inicio = 1'b0;
        M1     = 16'hAAAA;
        M2     = 16'h5555;
        H      = 2'b11;
        drain();
        repeat (4) @(negedge clock);

        issue(2'b01, 16'h00FF, 16'h0003, 16'h02FD, 1'b0, 1'b0);
        repeat (7) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_resultado", 32'(resultado), 32'h0);
        chk("arst_estouro", 32'(estouro), 32'h0);
        chk("arst_pronto", 32'(pronto), 32'h1);
        chk("arst_valido", 32'(valido), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        issue(2'b00, 16'h0002, 16'h0002, 16'h0004, 1'b0, 1'b1);
        repeat (25) @(negedge clock);
        drain();

        c0     = cyc;
        H      = 2'b00;
        M1     = 16'h1111;
        M2     = 16'h2222;
        inicio = 1'b1;
        for (int k = 0; k < 5; k++) begin
            x.r = 16'h3333;
            x.e = 1'b0;
            x.c = c0 + 1 + 2 * k;
            sb.push_back(x);
        end
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (valido) pulses++;
            if (i % 2 == 0) chk("thru_pronto", 32'(pronto), 32'h1);
        end
        inicio = 1'b0;
        chk("thru_pulses", 32'(pulses), 32'd5);
        repeat (4) @(negedge clock);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
